// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the RV64I instruction encoder: the request operation
// enum, the FSM state enum, the latched-request struct, the opcode / funct3 /
// funct7 constants and the ALU operation codes that select the R-type fields.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADDI = 4'd1,
        OP_LD   = 4'd2,
        OP_SD   = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_BEQ  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_WRITE,
        ST_FULL
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } req_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_SD   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [2:0] alu_funct3(alu_e alu);
        case (alu)
            ALU_AND: return F3_AND;
            ALU_OR:  return F3_OR;
            default: return F3_ADD;   // ADD and SUB share funct3
        endcase
    endfunction

    function automatic logic [6:0] alu_funct7(alu_e alu);
        return (alu == ALU_SUB) ? F7_ALT : F7_BASE;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Request handshake plus instruction-memory write bus of the encoder.
//   master : requester side, drives req_*, observes req_ready and imem_*
//   slave  : encoder side, drives req_ready and imem_*
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int DEPTH = 64
) ();

    logic                          req_valid;
    logic                          req_ready;
    instr_encoder_pkg::op_e        req_op;
    logic [4:0]                    req_rd;
    logic [4:0]                    req_rs1;
    logic [4:0]                    req_rs2;
    logic [12:0]                   req_imm;
    logic                          imem_we;
    logic [$clog2(DEPTH)-1:0]      imem_addr;
    logic [31:0]                   imem_wdata;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational packer: turns a latched request into a 32-bit RV64I
// instruction word and flags requests whose immediate cannot be represented
// or whose operation is unknown.
//   req_i     : latched request (op, rd, rs1, rs2, 13-bit signed imm)
//   word_o    : encoded instruction
//   illegal_o : 1 when the request must be rejected
// -----------------------------------------------------------------------------
module instr_pack
    import instr_encoder_pkg::*;
(
    input  req_t        req_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic fits12;
    alu_e alu;

    // A 13-bit value fits a 12-bit signed field when its top two bits agree.
    assign fits12 = (req_i.imm[12] == req_i.imm[11]);

    always_comb begin
        // NOTE: every output gets a default first so no path can leave it
        // unassigned, which would otherwise infer a latch.
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        alu       = ALU_ADD;

        case (req_i.op)
            OP_NOP: word_o = NOP_WORD;
            OP_ADDI: begin
                word_o    = {req_i.imm[11:0], req_i.rs1, F3_ADDI, req_i.rd, OPC_OP_IMM};
                illegal_o = !fits12;
            end
            OP_LD: begin
                word_o    = {req_i.imm[11:0], req_i.rs1, F3_LD, req_i.rd, OPC_LOAD};
                illegal_o = !fits12;
            end
            OP_SD: begin
                word_o    = {req_i.imm[11:5], req_i.rs2, req_i.rs1, F3_SD,
                             req_i.imm[4:0], OPC_STORE};
                illegal_o = !fits12;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                case (req_i.op)
                    OP_SUB:  alu = ALU_SUB;
                    OP_AND:  alu = ALU_AND;
                    OP_OR:   alu = ALU_OR;
                    default: alu = ALU_ADD;
                endcase
                word_o = {alu_funct7(alu), req_i.rs2, req_i.rs1, alu_funct3(alu),
                          req_i.rd, OPC_OP};
            end
            OP_BEQ: begin
                // Every even 13-bit value is within -4096..4094, so only the
                // alignment bit needs checking.
                word_o    = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1,
                             F3_BEQ, req_i.imm[4:1], req_i.imm[11], OPC_BRANCH};
                illegal_o = req_i.imm[0];
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts encode requests, packs them into RV64I words and writes them to
// consecutive instruction-memory words. Sequence per request:
// IDLE (accept) -> ENCODE (register word, range-check) -> WRITE (one strobe).
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous restart of write pointer / count, abandons work
//   bus      : slave side of instr_encoder_if (request + imem write bus)
//   err      : one-cycle pulse when a request is rejected
//   full     : DEPTH words written since reset/clear
//   count    : words written since reset/clear
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    instr_encoder_if.slave         bus,
    output logic                   err,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e          state_q, state_d;
    req_t            req_q;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     word;
    logic            illegal;
    logic            accept;

    instr_pack u_pack (
        .req_i     (req_q),
        .word_o    (word),
        .illegal_o (illegal)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        bus.imem_we   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = !clear;
                accept        = bus.req_valid && !clear;
                if (accept) state_d = ST_ENCODE;
            end
            ST_ENCODE: state_d = illegal ? ST_IDLE : ST_WRITE;
            ST_WRITE: begin
                // Strobe comes straight from the state so an asynchronous
                // reset drops it immediately, and a coinciding clear does not.
                bus.imem_we = 1'b1;
                ptr_d       = ptr_q + 1'b1;
                count_d     = count_q + 1'b1;
                state_d     = (count_q == CW'(DEPTH - 1)) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
        endcase

        // clear wins over everything, including the increment of a WRITE.
        if (clear) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, because their reset
            // value is visible on imem_wdata/imem_addr before the first write.
            state_q <= ST_IDLE;
            req_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= (state_q == ST_ENCODE) && illegal && !clear;
            if (accept) begin
                req_q <= '{op:  bus.req_op,  rd:  bus.req_rd, rs1: bus.req_rs1,
                           rs2: bus.req_rs2, imm: bus.req_imm};
            end
            // Word and address only move for a write that will really happen,
            // so the bus holds its last value otherwise.
            if ((state_q == ST_ENCODE) && !illegal && !clear) begin
                wdata_q <= word;
                addr_q  <= ptr_q;
            end
        end
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign err            = err_q;
    assign full           = (count_q == CW'(DEPTH));
    assign count          = count_q;

endmodule
